// File: rtl/boot_rom_mp.sv
// Multi-port boot ROM slave: round-robin arbitration over up to four TCDM ports, one ROM array,
// configurable read latency and error responses for out-of-range or write accesses.
module boot_rom_mp #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LATENCY        = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
  parameter logic [31:0] ERR_DATA       = 32'hBADA_CCE5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS*32-1:0]           add_i,
  input  logic [NUM_PORTS-1:0]              wen_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              r_valid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   r_rdata_o,
  output logic [NUM_PORTS-1:0]              r_opc_o,
  input  logic                              test_mode_i
);

  localparam int unsigned PtrW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned ByteOffW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WordAw   = ROM_ADDR_WIDTH - ByteOffW;
  localparam logic [DATA_WIDTH-1:0] ErrWord = {(DATA_WIDTH / 32){ERR_DATA}};

  // ROM image: word i holds 0xB0070000 + i (upper half inverted for 64-bit words).
  function automatic logic [DATA_WIDTH-1:0] rom_image(input logic [WordAw-1:0] a);
    logic [31:0] w;
    w = 32'hB007_0000 + 32'(a);
    return DATA_WIDTH'({~w, w});
  endfunction

  logic [PtrW-1:0] ptr_q, ptr_d, winner;
  logic [PtrW:0]   cand_sum;
  logic            found;

  // Search ptr, ptr+1, ... modulo NUM_PORTS for the first requester.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand_sum = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (cand_sum >= (PtrW + 1)'(NUM_PORTS)) cand_sum = cand_sum - (PtrW + 1)'(NUM_PORTS);
      if (!found && req_i[cand_sum[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[PtrW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[winner] = 1'b1;
    ptr_d = ptr_q;
    if (found) ptr_d = (32'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;
  end

  logic [31:0]       sel_add, off;
  logic              sel_read, in_range, acc_err, rom_cen;
  logic [WordAw-1:0] word_addr;

  always_comb begin
    sel_add   = add_i[32 * 32'(winner) +: 32];
    sel_read  = wen_i[winner];
    off       = sel_add - BASE_ADDR;
    in_range  = (off >> ROM_ADDR_WIDTH) == 32'd0;
    acc_err   = !(in_range && sel_read);
    rom_cen   = !(found && !acc_err);
    word_addr = off[ROM_ADDR_WIDTH-1:ByteOffW];
  end

  logic [DATA_WIDTH-1:0] rom_rdata_q;
  logic                  tag_vld_q [LATENCY];
  logic [PtrW-1:0]       tag_id_q  [LATENCY];
  logic                  tag_err_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rom_rdata_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
        tag_err_q[i] <= 1'b0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (!rom_cen) rom_rdata_q <= rom_image(word_addr);
      tag_vld_q[0] <= found;
      tag_id_q[0]  <= winner;
      tag_err_q[0] <= acc_err;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
        tag_err_q[i] <= tag_err_q[i-1];
      end
    end
  end

  // Stage-0 tag lines up with the macro output; errors substitute ERR_DATA there.
  logic [DATA_WIDTH-1:0] mac_data, out_data;
  assign mac_data = tag_err_q[0] ? ErrWord : rom_rdata_q;

  if (LATENCY == 1) begin : g_no_dstage
    assign out_data = mac_data;
  end else begin : g_dstage
    logic [DATA_WIDTH-1:0] data_q [LATENCY-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) data_q[i] <= '0;
      end else begin
        data_q[0] <= mac_data;
        for (int unsigned i = 1; i < LATENCY - 1; i++) data_q[i] <= data_q[i-1];
      end
    end
    assign out_data = data_q[LATENCY-2];
  end

  always_comb begin
    r_valid_o = '0;
    r_opc_o   = '0;
    if (tag_vld_q[LATENCY-1]) begin
      r_valid_o[tag_id_q[LATENCY-1]] = 1'b1;
      r_opc_o[tag_id_q[LATENCY-1]]   = tag_err_q[LATENCY-1];
    end
    r_rdata_o = {NUM_PORTS{out_data}};
  end

  logic unused_inputs;
  assign unused_inputs = ^{test_mode_i, be_i, wdata_i};

endmodule

// File: doc/boot_rom_mp.md
# boot_rom_mp

Multi-port, parametrised boot ROM slave on the SoC interconnect, successor to the single-port fixed-latency boot ROM. It serves up to four TCDM-style request ports from one `generic_rom` macro (`fpga_bootrom` under `PULP_FPGA_EMUL`) using round-robin arbitration. Read latency is configurable, and out-of-range addresses and writes return an error response. It sits at `SOC_MEM_MAP_BOOT_ROM_START_ADDR`, with one port per fabric master that fetches boot code, typically FC instruction and data ports plus debug.

## Interface
- `NUM_PORTS`, 2: request ports, 1..4.
- `ROM_ADDR_WIDTH`, 13: byte-address bits covered; ROM size = 2^ROM_ADDR_WIDTH bytes.
- `DATA_WIDTH`, 32: word width, 32 or 64.
- `LATENCY`, 1: cycles from grant to `r_valid_o`, 1..4.
- `BASE_ADDR`, `SOC_MEM_MAP_BOOT_ROM_START_ADDR`: byte base address.
- `ERR_DATA`, 32'hBADACCE5: `r_rdata_o` value on error, replicated to `DATA_WIDTH`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NUM_PORTS  request per port.
- `add_i`  in  NUM_PORTS×32  byte address per port.
- `wen_i`  in  NUM_PORTS  1 = read, 0 = write.
- `be_i`  in  NUM_PORTS×DATA_WIDTH/8  ignored.
- `wdata_i`  in  NUM_PORTS×DATA_WIDTH  ignored.
- `gnt_o`  out  NUM_PORTS  grant, combinational.
- `r_valid_o`  out  NUM_PORTS  response valid.
- `r_rdata_o`  out  NUM_PORTS×DATA_WIDTH  read data.
- `r_opc_o`  out  NUM_PORTS  1 = error response.
- `test_mode_i`  in  1  passed to the macro; no functional effect.

## Operation
- **Arbitration:** round-robin with priority pointer `ptr` (log2 NUM_PORTS bits).
  - The winner is the first requesting port searching `ptr`, `ptr+1`, … modulo NUM_PORTS.
  - `gnt_o[p] = req_i[p] & (p == winner)`. At most one grant per cycle.
  - On any grant, `ptr <= winner+1` (mod NUM_PORTS). With no request, `ptr` holds.
  - With NUM_PORTS = 1, `gnt_o = req_i`.
- **Decode:** `off = add_i[winner] - BASE_ADDR`, computed in 32 bits with wrap.
  - In range iff `off < 2^ROM_ADDR_WIDTH` (unsigned).
  - Word address = `off[ROM_ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]`. Low bits are ignored, so unaligned reads return the containing word.
- **Macro enable:** `CEN` is low only in a grant cycle with an in-range read.
  - Error accesses (out of range, or `wen_i=0`) are granted but do not enable the macro.
- **Response tag pipeline:** LATENCY stages of {valid, port id, err}, loaded in the grant cycle.
  - The macro's 1-cycle output, muxed with `ERR_DATA` on err, is registered through LATENCY-1 further data stages.
  - The stage-LATENCY entry drives `r_valid_o[id]=1`, `r_opc_o[id]=err`, and `r_rdata_o[id]` = data. All other ports have `r_valid_o=0`, `r_opc_o=0`.
- **No backpressure:** responses are never stalled. Throughput is one access per cycle; a new grant is allowed every cycle.
- **Data when invalid:** `r_rdata_o` is don't-care when `r_valid_o=0`. All ports may share the same data bus.

## Timing
- **Reset** (async, immediate): `ptr=0`, all tag stages invalid. Consequently `r_valid_o=0` and `r_opc_o=0`; data stage registers reset to 0.
- **Grant:** `gnt_o` is in the same cycle as `req_i`. A combinational path from `req_i`/`ptr` to `gnt_o` is required.
- **Response:** for a grant in cycle T, `r_valid_o` is asserted in cycle T+LATENCY for exactly one cycle. The response order equals the grant order.
- **Simultaneous events:** a grant and a response in the same cycle are independent. Back-to-back grants to the same or different ports give back-to-back responses.
- **Request without grant:** a port that requests but is not granted must hold its request. No state is kept for it.
- **Reset mid-operation:** in-flight responses are dropped, with no `r_valid_o` after reset release until a new grant. `ptr` returns to 0.

## Test plan
- **Single read, LATENCY=1:** port 0 reads 0x1A000004. Required: `gnt_o[0]` in the same cycle; next cycle `r_valid_o[0]=1`, `r_opc_o=0`, `r_rdata_o[0]` = ROM word 1.
- **LATENCY=3, back-to-back:** port 1 reads words 0, 1, 2 on consecutive cycles. Required: three consecutive valids starting 3 cycles after the first grant, in order, with data matching the ROM image.
- **Contention, NUM_PORTS=3:** all ports request continuously from reset. Required: grants cycle 0,1,2,0,1,2; each response is routed only to the granted port.
- **Errors:**
  - Read at 0x1A002000 (`off=2^13`): granted, `CEN` stays high, `r_opc_o=1`, `r_rdata_o=0xBADACCE5`.
  - Write (`wen_i=0`) at 0x1A000000: same error response.
  - Read at address 0x00000000 (wrapped offset): error.
- **Unaligned:** read 0x1A000007 with DATA_WIDTH=32. Required: word 1, `r_opc_o=0`.
- **Reset mid-flight, LATENCY=4:** assert `rst_ni=0` 2 cycles after a grant, release 1 cycle later. Required: no `r_valid_o` afterwards, and the next contention grant goes to port 0.
